// File: rtl/uart_alu_host.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | uart_alu_host: frames {opcode,A,B} into a 12-byte command, collects a 4-byte |
// | little-endian result or times out.            Revision: 1.0                  |
// +-----------------------------------------------------------------------------+
module uart_alu_host #(
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int CNT_W          = 21
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [7:0]  cmd_opcode_i,
    input  logic [31:0] cmd_a_i,
    input  logic [31:0] cmd_b_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_TIMEOUT   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] C_TIMER_MAX = '1;

    state_t            r_state,     w_state;
    logic [7:0]        r_op,        w_op;
    logic [31:0]       r_a,         w_a;
    logic [31:0]       r_b,         w_b;
    logic [3:0]        r_idx,       w_idx;
    logic [1:0]        r_cnt,       w_cnt;
    logic [CNT_W-1:0]  r_timer,     w_timer;
    logic [CNT_W-1:0]  w_timer_inc;
    logic [31:0]       r_result,    w_result;
    logic              r_cmd_ready, w_cmd_ready;
    logic [7:0]        r_tx_data,   w_tx_data;
    logic              r_tx_valid,  w_tx_valid;
    logic              r_rsp_valid, w_rsp_valid;
    logic [31:0]       r_rsp_data,  w_rsp_data;
    logic              r_rsp_to,    w_rsp_to;

    function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic [7:0] op,
                                              input logic [31:0] a, input logic [31:0] b);
        case (idx)
            4'd0:    return op;
            4'd2:    return 8'h0C;
            4'd4:    return a[7:0];
            4'd5:    return a[15:8];
            4'd6:    return a[23:16];
            4'd7:    return a[31:24];
            4'd8:    return b[7:0];
            4'd9:    return b[15:8];
            4'd10:   return b[23:16];
            4'd11:   return b[31:24];
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        w_state     = r_state;
        w_op        = r_op;
        w_a         = r_a;
        w_b         = r_b;
        w_idx       = r_idx;
        w_cnt       = r_cnt;
        w_timer     = r_timer;
        w_result    = r_result;
        w_cmd_ready = r_cmd_ready;
        w_tx_data   = r_tx_data;
        w_tx_valid  = r_tx_valid;
        w_rsp_valid = r_rsp_valid;
        w_rsp_data  = r_rsp_data;
        w_rsp_to    = r_rsp_to;
        w_timer_inc = (r_timer == C_TIMER_MAX) ? r_timer : r_timer + 1'b1;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid_i && r_cmd_ready) begin
                    w_op        = cmd_opcode_i;
                    w_a         = cmd_a_i;
                    w_b         = cmd_b_i;
                    w_idx       = 4'd0;
                    w_tx_data   = cmd_opcode_i;
                    w_tx_valid  = 1'b1;
                    w_cmd_ready = 1'b0;
                    w_state     = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_ready_i) begin
                    if (r_idx == 4'd11) begin
                        w_tx_valid = 1'b0;
                        w_tx_data  = 8'h00;
                        w_cnt      = 2'd0;
                        w_timer    = '0;
                        w_state    = S_WAIT;
                    end else begin
                        w_idx     = r_idx + 4'd1;
                        w_tx_data = frame_byte(r_idx + 4'd1, r_op, r_a, r_b);
                    end
                end
            end
            S_WAIT: begin
                // A byte arriving on the expiry cycle takes priority over the timeout.
                if (rx_valid_i) begin
                    w_timer                     = '0;
                    w_cnt                       = r_cnt + 2'd1;
                    w_result[{r_cnt, 3'b000} +: 8] = rx_data_i;
                    if (r_cnt == 2'd3) begin
                        w_rsp_valid = 1'b1;
                        w_rsp_data  = w_result;
                        w_rsp_to    = 1'b0;
                        w_state     = S_RESP;
                    end
                end else if (w_timer_inc >= C_TIMEOUT) begin
                    w_timer     = w_timer_inc;
                    w_rsp_valid = 1'b1;
                    w_rsp_data  = 32'h0;
                    w_rsp_to    = 1'b1;
                    w_state     = S_RESP;
                end else begin
                    w_timer = w_timer_inc;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    w_rsp_valid = 1'b0;
                    w_rsp_data  = 32'h0;
                    w_rsp_to    = 1'b0;
                    w_cmd_ready = 1'b1;
                    w_state     = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_op        <= 8'h00;
            r_a         <= 32'h0;
            r_b         <= 32'h0;
            r_idx       <= 4'd0;
            r_cnt       <= 2'd0;
            r_timer     <= '0;
            r_result    <= 32'h0;
            r_cmd_ready <= 1'b1;
            r_tx_data   <= 8'h00;
            r_tx_valid  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'h0;
            r_rsp_to    <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_op        <= w_op;
            r_a         <= w_a;
            r_b         <= w_b;
            r_idx       <= w_idx;
            r_cnt       <= w_cnt;
            r_timer     <= w_timer;
            r_result    <= w_result;
            r_cmd_ready <= w_cmd_ready;
            r_tx_data   <= w_tx_data;
            r_tx_valid  <= w_tx_valid;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_data  <= w_rsp_data;
            r_rsp_to    <= w_rsp_to;
        end
    end

    assign cmd_ready_o   = r_cmd_ready;
    assign tx_data_o     = r_tx_data;
    assign tx_valid_o    = r_tx_valid;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_data_o    = r_rsp_data;
    assign rsp_timeout_o = r_rsp_to;

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_host.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_uart_alu_host: directed bench for uart_alu_host (TIMEOUT_CYCLES = 50).    |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_uart_alu_host;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_timeout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_alu_host #(
        .TIMEOUT_CYCLES(50),
        .CNT_W         (21)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_opcode_i (cmd_opcode),
        .cmd_a_i      (cmd_a),
        .cmd_b_i      (cmd_b),
        .tx_data_o    (tx_data),
        .tx_valid_o   (tx_valid),
        .tx_ready_i   (tx_ready),
        .rx_data_i    (rx_data),
        .rx_valid_i   (rx_valid),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data),
        .rsp_timeout_o(rsp_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents a command for one accepting edge, then scrambles the inputs.
    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid  = 1'b0;
        cmd_opcode = 8'hFF;
        cmd_a      = $urandom;
        cmd_b      = $urandom;
    endtask

    // Frame byte i sits at fr[8*i +: 8]; tx_ready must already be high.
    task automatic stream_fast(input logic [95:0] fr, input string tag);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("%s valid%0d", tag, i), {31'b0, tx_valid}, 32'd1);
            check($sformatf("%s byte%0d", tag, i), {24'b0, tx_data}, {24'b0, fr[8*i +: 8]});
            tick();
        end
        check($sformatf("%s end", tag), {31'b0, tx_valid}, 32'd0);
    endtask

    task automatic rx_byte(input logic [7:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] fr;
        logic        rdy;
        int          k;
        int          cyc;
        int          n;

        rst_n      = 1'b0;
        cmd_valid  = 1'b1;
        cmd_opcode = 8'h01;
        cmd_a      = 32'h1;
        cmd_b      = 32'h2;
        tx_ready   = 1'b0;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        rsp_ready  = 1'b0;

        // T1: reset with cmd_valid held high
        repeat (3) tick();
        check("t1 cmd_ready",   {31'b0, cmd_ready},   32'd1);
        check("t1 tx_valid",    {31'b0, tx_valid},    32'd0);
        check("t1 tx_data",     {24'b0, tx_data},     32'd0);
        check("t1 rsp_valid",   {31'b0, rsp_valid},   32'd0);
        check("t1 rsp_timeout", {31'b0, rsp_timeout}, 32'd0);
        check("t1 rsp_data",    rsp_data,             32'd0);
        cmd_valid = 1'b0;
        rst_n     = 1'b1;
        tick();
        check("t1 idle ready",  {31'b0, cmd_ready},   32'd1);

        // T2: back-to-back frame
        fr       = 96'hAABBCCDD_11223344_000C0001;
        tx_ready = 1'b1;
        issue(8'h01, 32'h11223344, 32'hAABBCCDD);
        check("t2 cmd_ready low", {31'b0, cmd_ready}, 32'd0);
        stream_fast(fr, "t2");

        // T4: response with gaps, then held by consumer
        rx_byte(8'h78);
        repeat (3) tick();
        rx_byte(8'h56);
        tick();
        rx_byte(8'h34);
        repeat (5) tick();
        check("t4 not early", {31'b0, rsp_valid}, 32'd0);
        rx_byte(8'h12);
        check("t4 rsp_valid",   {31'b0, rsp_valid},   32'd1);
        check("t4 rsp_data",    rsp_data,             32'h12345678);
        check("t4 rsp_timeout", {31'b0, rsp_timeout}, 32'd0);
        check("t4 no overlap",  {31'b0, cmd_ready},   32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t4 hold valid%0d", i), {31'b0, rsp_valid}, 32'd1);
            check($sformatf("t4 hold data%0d", i),  rsp_data,           32'h12345678);
        end
        handshake();
        check("t4 rsp_valid drop", {31'b0, rsp_valid},   32'd0);
        check("t4 timeout drop",   {31'b0, rsp_timeout}, 32'd0);
        check("t4 cmd_ready",      {31'b0, cmd_ready},   32'd1);

        // T3: random backpressure on the same frame
        tx_ready = 1'b0;
        issue(8'h01, 32'h11223344, 32'hAABBCCDD);
        k   = 0;
        cyc = 0;
        while (k < 12 && cyc < 300) begin
            check($sformatf("t3 valid c%0d", cyc), {31'b0, tx_valid}, 32'd1);
            check($sformatf("t3 byte%0d c%0d", k, cyc), {24'b0, tx_data}, {24'b0, fr[8*k +: 8]});
            rdy      = 1'($urandom_range(0, 1));
            tx_ready = rdy;
            tick();
            if (rdy) k++;
            cyc++;
        end
        check("t3 bytes sent", k, 32'd12);
        check("t3 end", {31'b0, tx_valid}, 32'd0);
        tx_ready = 1'b1;
        rx_byte(8'hEF);
        rx_byte(8'hBE);
        rx_byte(8'hAD);
        rx_byte(8'hDE);
        check("t3 rsp_data", rsp_data, 32'hDEADBEEF);
        handshake();

        // T5: timeout 50 edges after the second byte is captured
        issue(8'h05, 32'h1, 32'h2);
        repeat (12) tick();
        check("t5 frame end", {31'b0, tx_valid}, 32'd0);
        rx_byte(8'hAA);
        rx_byte(8'hBB);
        n = 0;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        check("t5 latency",     n,                    32'd50);
        check("t5 rsp_valid",   {31'b0, rsp_valid},   32'd1);
        check("t5 rsp_timeout", {31'b0, rsp_timeout}, 32'd1);
        check("t5 rsp_data",    rsp_data,             32'd0);
        rx_byte(8'h99);
        check("t5 stray valid",   {31'b0, rsp_valid},   32'd1);
        check("t5 stray timeout", {31'b0, rsp_timeout}, 32'd1);
        check("t5 stray data",    rsp_data,             32'd0);
        handshake();
        check("t5 rsp_valid drop", {31'b0, rsp_valid},   32'd0);
        check("t5 timeout drop",   {31'b0, rsp_timeout}, 32'd0);
        rx_byte(8'h77);
        check("t5 idle ready",    {31'b0, cmd_ready}, 32'd1);
        check("t5 idle tx_valid", {31'b0, tx_valid},  32'd0);
        check("t5 idle rsp",      {31'b0, rsp_valid}, 32'd0);

        // T6: reset while byte index 6 is presented
        issue(8'h02, 32'h55667788, 32'h99AABBCC);
        repeat (6) tick();
        check("t6 idx6 byte", {24'b0, tx_data}, 32'h66);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6 cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("t6 tx_valid",  {31'b0, tx_valid},  32'd0);
        check("t6 tx_data",   {24'b0, tx_data},   32'd0);
        issue(8'h0A, 32'hDEADBEEF, 32'h00000001);
        stream_fast(96'h00000001_DEADBEEF_000C000A, "t6");
        rx_byte(8'h01);
        rx_byte(8'h02);
        rx_byte(8'h03);
        rx_byte(8'h04);
        check("t6 rsp_data",    rsp_data,             32'h04030201);
        check("t6 rsp_timeout", {31'b0, rsp_timeout}, 32'd0);
        handshake();
        check("t6 idle", {31'b0, cmd_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
